// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the UART frame loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_frame_pkg;

   // Loader FSM states: two header-hunt states, then hi/lo payload bytes
   typedef enum logic [1:0] {
      HUNT_A5 = 2'd0,
      HUNT_5A = 2'd1,
      BYTE_HI = 2'd2,
      BYTE_LO = 2'd3
   } state_t;

   localparam logic [7:0] SYNC0   = 8'hA5;
   localparam logic [7:0] SYNC1   = 8'h5A;
   localparam int         PIXEL_W = 12;

   // 12-bit pixel as stored in the frame buffer
   typedef struct packed {
      logic [7:0] hi;
      logic [3:0] lo_nib;
   } pixel_t;

   // Only the top nibble of the low byte is kept; the caller passes it in
   function automatic pixel_t pack_pixel(input logic [7:0] hi, input logic [3:0] lo_nib);
      pixel_t p;
      p.hi     = hi;
      p.lo_nib = lo_nib;
      return p;
   endfunction

endpackage

// File: rtl/uart_frame_loader_if.sv
// Bundle of the UART-FIFO read side and frame-buffer write side of the loader.
// Latency: n/a (wiring only).
// Backpressure: none; the FIFO side is pop-on-not-empty, the memory side is write-only.
// master: the loader (drives rd_uart, mem_w_*, frame_done, sync_err, busy)
// slave : the environment (drives rx_data, rx_empty)
interface uart_frame_loader_if
   import uart_frame_pkg::*;
#(
   parameter int ADDR_W = 19
);
   logic [7:0]         rx_data;
   logic               rx_empty;
   logic               rd_uart;
   logic               mem_w_en;
   logic [ADDR_W-1:0]  mem_w_addr;
   logic [PIXEL_W-1:0] mem_w_data;
   logic               frame_done;
   logic               sync_err;
   logic               busy;

   modport master (
      input  rx_data, rx_empty,
      output rd_uart, mem_w_en, mem_w_addr, mem_w_data, frame_done, sync_err, busy
   );

   modport slave (
      output rx_data, rx_empty,
      input  rd_uart, mem_w_en, mem_w_addr, mem_w_data, frame_done, sync_err, busy
   );
endinterface

// File: rtl/uart_frame_loader_byte_timeout.sv
// Idle counter between payload bytes; flags terminal count combinationally.
// Latency: tc asserts in the cycle the count sits at TIMEOUT_CYCLES-1 with en high.
// Backpressure: none; clr has priority over en, count holds once terminal.
// Ports: clk, rst (sync, active-high), clr (restart at 0), en (count this cycle), tc (terminal).
module byte_timeout #(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam int              CNT_W  = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;

   assign tc = en && (cnt_q == TC_VAL);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (en && !tc) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end
endmodule

// File: rtl/uart_frame_loader.sv
// Header hunt (A5 5A) then packs byte pairs into 12-bit pixels written at incrementing addresses.
// Latency: one clk from popping the low byte to mem_w_en; at most one write per 2 clks.
// Backpressure: never stalls the FIFO (pops whenever non-empty); a stalled payload times out and resyncs.
// Ports: clk, rst (sync, active-high); bus.master: rx_data/rx_empty in, rd_uart out,
//        mem_w_en/mem_w_addr/mem_w_data out, frame_done/sync_err pulses, busy level.
module uart_frame_loader
   import uart_frame_pkg::*;
#(
   parameter int IMAGE_WIDTH    = 800,
   parameter int IMAGE_HEIGHT   = 600,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                clk,
   input  logic                rst,
   uart_frame_loader_if.master bus
);
   localparam int               NPIX      = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int               ADDR_W    = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [7:0]         hi_q, hi_d;
   logic               w_en_q, w_en_d;
   logic [ADDR_W-1:0]  w_addr_q, w_addr_d;
   logic [PIXEL_W-1:0] w_data_q, w_data_d;
   logic               done_q, done_d;
   logic               serr_q, serr_d;

   logic pop;
   logic in_payload;
   logic tmo_tc;

   assign pop        = !bus.rx_empty && !rst;
   assign in_payload = (state_q == BYTE_HI) || (state_q == BYTE_LO);

   // Counter only runs mid-payload; outside it is held clear so every frame starts fresh
   byte_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk (clk),
      .rst (rst),
      .clr (pop || !in_payload),
      .en  (in_payload && bus.rx_empty),
      .tc  (tmo_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= HUNT_A5;
         addr_q   <= '0;
         hi_q     <= '0;
         w_en_q   <= 1'b0;
         w_addr_q <= '0;
         w_data_q <= '0;
         done_q   <= 1'b0;
         serr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         hi_q     <= hi_d;
         w_en_q   <= w_en_d;
         w_addr_q <= w_addr_d;
         w_data_q <= w_data_d;
         done_q   <= done_d;
         serr_q   <= serr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      hi_d     = hi_q;
      w_en_d   = 1'b0;
      w_addr_d = w_addr_q;
      w_data_d = w_data_q;
      done_d   = 1'b0;
      serr_d   = 1'b0;

      // tc can only fire mid-payload with no pop, so it never collides with a byte
      if (tmo_tc) begin
         state_d = HUNT_A5;
         addr_d  = '0;
         hi_d    = '0;
         serr_d  = 1'b1;
      end else if (pop) begin
         unique case (state_q)
            HUNT_A5: begin
               if (bus.rx_data == SYNC0) state_d = HUNT_5A;
            end
            HUNT_5A: begin
               // A repeated A5 may itself be the start of the real header
               if (bus.rx_data == SYNC1) begin
                  state_d = BYTE_HI;
                  addr_d  = '0;
               end else if (bus.rx_data != SYNC0) begin
                  state_d = HUNT_A5;
               end
            end
            BYTE_HI: begin
               hi_d    = bus.rx_data;
               state_d = BYTE_LO;
            end
            BYTE_LO: begin
               w_en_d   = 1'b1;
               w_addr_d = addr_q;
               w_data_d = pack_pixel(hi_q, bus.rx_data[7:4]);
               if (addr_q == LAST_ADDR) begin
                  done_d  = 1'b1;
                  addr_d  = '0;
                  state_d = HUNT_A5;
               end else begin
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = BYTE_HI;
               end
            end
            default: state_d = HUNT_A5;
         endcase
      end
   end

   // Outputs are forced low while rst is held so nothing leaks during reset
   assign bus.rd_uart    = pop;
   assign bus.mem_w_en   = w_en_q && !rst;
   assign bus.mem_w_addr = rst ? '0 : w_addr_q;
   assign bus.mem_w_data = rst ? '0 : w_data_q;
   assign bus.frame_done = done_q && !rst;
   assign bus.sync_err   = serr_q && !rst;
   assign bus.busy       = in_payload && !rst;

endmodule

// File: tb/tb_uart_frame_loader.sv
module tb_uart_frame_loader;
   localparam int W    = 4;
   localparam int H    = 4;
   localparam int T    = 50;
   localparam int NPIX = W * H;
   localparam int AW   = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_frame_loader_if #(.ADDR_W(AW)) bus ();

   uart_frame_loader #(
      .IMAGE_WIDTH   (W),
      .IMAGE_HEIGHT  (H),
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int cyc;
      int addr;
      int data;
      bit done;
   } wr_t;

   wr_t wrq[$];
   int  sync_q[$];
   int  pop_q[$];
   int  cyc        = 0;
   int  last_pop   = 0;
   int  stray_done = 0;
   int  checks     = 0;
   int  failures   = 0;

   // Event logger, sampled mid-cycle; inputs change 1ns after posedge
   always @(negedge clk) begin
      wr_t w;
      cyc++;
      if (bus.rd_uart) begin
         last_pop = cyc;
         pop_q.push_back(cyc);
      end
      if (bus.mem_w_en) begin
         w.cyc  = cyc;
         w.addr = int'(bus.mem_w_addr);
         w.data = int'(bus.mem_w_data);
         w.done = bus.frame_done;
         wrq.push_back(w);
      end else if (bus.frame_done) begin
         stray_done++;
      end
      if (bus.sync_err) sync_q.push_back(cyc);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic put(input logic [7:0] b);
      @(posedge clk);
      #1;
      bus.rx_data  = b;
      bus.rx_empty = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         bus.rx_empty = 1'b1;
      end
   endtask

   task automatic clear_logs();
      wrq.delete();
      sync_q.delete();
      pop_q.delete();
   endtask

   initial begin
      // ---- reset: FIFO non-empty, nothing may be popped ----
      bus.rx_data  = 8'hA5;
      bus.rx_empty = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rd_uart", bus.rd_uart, 0);
      check("rst_w_en", bus.mem_w_en, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.frame_done, 0);
      check("rst_serr", bus.sync_err, 0);
      rst          = 1'b0;
      bus.rx_empty = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_w_en", bus.mem_w_en, 0);
      check("post_rst_addr", bus.mem_w_addr, 0);
      check("post_rst_data", bus.mem_w_data, 0);
      check("post_rst_busy", bus.busy, 0);
      clear_logs();

      // ---- T1: full frame back-to-back ----
      put(8'hA5);
      put(8'h5A);
      for (int i = 0; i < NPIX; i++) begin
         put(8'(i));
         if (i == 0) check("t1_busy_mid", bus.busy, 1);
         put(8'hF0 | 8'(i));
      end
      idle(3);
      check("t1_nwr", wrq.size(), NPIX);
      for (int i = 0; i < NPIX && i < wrq.size(); i++) begin
         check($sformatf("t1_addr%0d", i), wrq[i].addr, i);
         check($sformatf("t1_data%0d", i), wrq[i].data, (i << 4) | 15);
         check($sformatf("t1_done%0d", i), wrq[i].done, (i == NPIX - 1) ? 1 : 0);
      end
      if (wrq.size() == NPIX && pop_q.size() >= 4) begin
         check("t1_latency", wrq[0].cyc, pop_q[3] + 1);
         check("t1_spacing", wrq[NPIX-1].cyc - wrq[0].cyc, 2 * (NPIX - 1));
      end
      check("t1_busy_after", bus.busy, 0);
      check("t1_no_serr", sync_q.size(), 0);
      clear_logs();

      // ---- T2: junk then header with repeated A5 ----
      put(8'h00); put(8'hA5); put(8'hA5); put(8'h5A); put(8'h12); put(8'h34);
      idle(3);
      check("t2_nwr", wrq.size(), 1);
      if (wrq.size() >= 1) begin
         check("t2_addr", wrq[0].addr, 0);
         check("t2_data", wrq[0].data, 32'h123);
         check("t2_done", wrq[0].done, 0);
      end
      // T2 leaves the FSM mid-frame at addr1; a timeout brings it back to hunt
      idle(T + 5);
      check("t2_serr", sync_q.size(), 1);
      clear_logs();

      // ---- T3: bad header ignored, good header accepted ----
      put(8'hA5); put(8'h33); put(8'h5A); put(8'h12); put(8'h34);
      idle(3);
      check("t3_bad_nwr", wrq.size(), 0);
      check("t3_bad_busy", bus.busy, 0);
      put(8'hA5); put(8'h5A); put(8'hAB); put(8'hCD);
      idle(3);
      check("t3_nwr", wrq.size(), 1);
      if (wrq.size() >= 1) begin
         check("t3_addr", wrq[0].addr, 0);
         check("t3_data", wrq[0].data, 32'hABC);
      end
      idle(T + 5);
      clear_logs();

      // ---- T4: stall mid-frame times out, next frame restarts at 0 ----
      put(8'hA5); put(8'h5A); put(8'h11); put(8'h22); put(8'h33);
      idle(60);
      check("t4_nwr", wrq.size(), 1);
      if (wrq.size() >= 1) check("t4_data", wrq[0].data, 32'h112);
      check("t4_nserr", sync_q.size(), 1);
      // pop sampled at negedge c0 is consumed at posedge c0+1; sync_err rises T edges later
      if (sync_q.size() >= 1) check("t4_serr_time", sync_q[0], last_pop + 1 + T);
      check("t4_busy", bus.busy, 0);
      clear_logs();
      put(8'hA5); put(8'h5A); put(8'h44); put(8'h55);
      idle(3);
      check("t4_re_nwr", wrq.size(), 1);
      if (wrq.size() >= 1) begin
         check("t4_re_addr", wrq[0].addr, 0);
         check("t4_re_data", wrq[0].data, 32'h445);
      end
      idle(T + 5);
      clear_logs();

      // ---- T5: T-1 idle cycles between payload bytes are tolerated ----
      put(8'hA5); put(8'h5A);
      for (int i = 0; i < NPIX; i++) begin
         put(8'h80 + 8'(i));
         idle(T - 1);
         put(8'h3C);
         if (i != NPIX - 1) idle(T - 1);
      end
      idle(3);
      check("t5_nwr", wrq.size(), NPIX);
      check("t5_nserr", sync_q.size(), 0);
      for (int i = 0; i < NPIX && i < wrq.size(); i++) begin
         check($sformatf("t5_addr%0d", i), wrq[i].addr, i);
         check($sformatf("t5_data%0d", i), wrq[i].data, ((32'h80 + i) << 4) | 3);
      end
      if (wrq.size() == NPIX) check("t5_done", wrq[NPIX-1].done, 1);
      clear_logs();

      // ---- T6: reset after 5 pixels ----
      put(8'hA5); put(8'h5A);
      for (int i = 0; i < 5; i++) begin
         put(8'h20 + 8'(i));
         put(8'h50);
      end
      idle(2);
      check("t6_pre_nwr", wrq.size(), 5);
      check("t6_pre_busy", bus.busy, 1);
      @(posedge clk);
      #1;
      rst          = 1'b1;
      bus.rx_data  = 8'h66;
      bus.rx_empty = 1'b0;
      #1;
      check("t6_rst_rd_uart", bus.rd_uart, 0);
      check("t6_rst_busy", bus.busy, 0);
      check("t6_rst_w_en", bus.mem_w_en, 0);
      @(posedge clk);
      #1;
      check("t6_rst2_rd_uart", bus.rd_uart, 0);
      rst          = 1'b0;
      bus.rx_empty = 1'b1;
      #1;
      check("t6_post_busy", bus.busy, 0);
      put(8'h77); put(8'h88);
      idle(3);
      check("t6_no_more_wr", wrq.size(), 5);
      put(8'hA5); put(8'h5A); put(8'h9A); put(8'hBC);
      idle(3);
      check("t6_new_nwr", wrq.size(), 6);
      if (wrq.size() >= 6) begin
         check("t6_new_addr", wrq[5].addr, 0);
         check("t6_new_data", wrq[5].data, 32'h9AB);
      end
      check("t6_nserr", sync_q.size(), 0);
      check("stray_done", stray_done, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
